// File: rtl/dma_ctrl.sv
// Single-channel DMA engine: copies data_qty_i words from src to dst one burst at a time,
// staging each read burst in a local FIFO before writing it back out.
module dma_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dma_en_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [DATA_W-1:0] data_qty_i,
  output logic              dma_fin_o,
  output logic              dma_busy_o,
  output logic              dma_err_o,
  output logic              rd_req_valid_o,
  input  logic              rd_req_ready_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [LEN_W-1:0]  rd_len_o,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_last_i,
  input  logic [1:0]        rd_resp_i,
  output logic              wr_req_valid_o,
  input  logic              wr_req_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [LEN_W-1:0]  wr_len_o,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              wr_last_o,
  input  logic              bresp_valid_i,
  output logic              bresp_ready_o,
  input  logic [1:0]        bresp_i
);

  localparam int PW = $clog2(MAX_BURST);
  localparam int BW = PW + 1;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, WR_RESP, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [DATA_W-1:0] rem_q;
  logic              err_q;
  logic [BW-1:0]     burst, burst_m1, wr_beat_q;
  logic [DATA_W-1:0] mem [MAX_BURST];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [BW-1:0]     cnt_q;
  logic              start, rd_req_hs, rd_beat, rd_bad, wr_req_hs, wr_beat, bresp_hs;
  logic              fifo_push, fifo_pop;

  // Burst size is derived from the remaining count, which only moves on the write response.
  assign burst     = (rem_q >= DATA_W'(MAX_BURST)) ? BW'(MAX_BURST) : rem_q[BW-1:0];
  assign burst_m1  = burst - BW'(1);
  assign start     = (state == IDLE) && dma_en_i;
  assign rd_bad    = (rd_resp_i != 2'b00);
  assign rd_req_hs = rd_req_valid_o && rd_req_ready_i;
  assign rd_beat   = rd_ready_o && rd_valid_i;
  assign wr_req_hs = wr_req_valid_o && wr_req_ready_i;
  assign wr_beat   = wr_valid_o && wr_ready_i;
  assign bresp_hs  = bresp_valid_i && bresp_ready_o;
  assign fifo_push = rd_beat && (cnt_q != BW'(MAX_BURST));
  assign fifo_pop  = wr_beat;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (dma_en_i) state_nxt = (data_qty_i == '0) ? DONE : RD_REQ;
      RD_REQ:  if (rd_req_hs) state_nxt = RD_DATA;
      RD_DATA: if (rd_beat && rd_last_i) state_nxt = (err_q || rd_bad) ? DONE : WR_REQ;
      WR_REQ:  if (wr_req_hs) state_nxt = WR_DATA;
      WR_DATA: if (wr_beat && wr_last_o) state_nxt = WR_RESP;
      WR_RESP: if (bresp_hs)
                 state_nxt = (bresp_i != 2'b00 || rem_q == DATA_W'(burst)) ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All valids come from registered state and FIFO occupancy, never from a ready input.
  always_comb begin
    dma_fin_o      = (state == DONE);
    dma_busy_o     = (state != IDLE);
    dma_err_o      = err_q;
    rd_req_valid_o = (state == RD_REQ);
    rd_addr_o      = src_q;
    rd_len_o       = (state == RD_REQ) ? LEN_W'(burst_m1) : '0;
    rd_ready_o     = (state == RD_DATA);
    wr_req_valid_o = (state == WR_REQ);
    wr_addr_o      = dst_q;
    wr_len_o       = (state == WR_REQ) ? LEN_W'(burst_m1) : '0;
    wr_valid_o     = (state == WR_DATA) && (cnt_q != '0);
    wr_data_o      = wr_valid_o ? mem[rptr_q] : '0;
    wr_last_o      = wr_valid_o && (wr_beat_q == burst_m1);
    bresp_ready_o  = (state == WR_RESP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      wr_beat_q <= '0;
    end else begin
      if (start) begin
        src_q <= src_addr_i;
        dst_q <= dst_addr_i;
        rem_q <= data_qty_i;
        err_q <= 1'b0;
      end
      if (rd_beat && rd_bad) err_q <= 1'b1;
      if (wr_req_hs)    wr_beat_q <= '0;
      else if (wr_beat) wr_beat_q <= wr_beat_q + BW'(1);
      if (bresp_hs) begin
        src_q <= src_q + ADDR_W'({burst, 2'b00});
        dst_q <= dst_q + ADDR_W'({burst, 2'b00});
        rem_q <= rem_q - DATA_W'(burst);
        if (bresp_i != 2'b00) err_q <= 1'b1;
      end
    end
  end

  // FIFO bookkeeping; DONE discards whatever a failed read burst left behind.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (state == DONE) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (fifo_push) wptr_q <= wptr_q + PW'(1);
      if (fifo_pop)  rptr_q <= rptr_q + PW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   cnt_q <= cnt_q + BW'(1);
        2'b01:   cnt_q <= cnt_q - BW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage array has no reset; occupancy is tracked by the reset pointers and count.
  always_ff @(posedge clk) begin
    if (fifo_push) mem[wptr_q] <= rd_data_i;
  end

endmodule
